dlx_rf_param: RTL and testbench
===============================

// Module: dlx_rf_param
// PURPOSE
//  Parametrised DLX general-purpose register file: next generation of the 32x32 2R1W file.
//  Provides configurable width, depth and read-port count, plus optional write-to-read bypass
//  and optional registered reads.
//  Adds a sequential bulk-clear engine (one register per cycle) so the file can be wiped
//  without a full reset.
//  Sits in the decode stage; the write port is driven by write-back.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of read ports (1..4)
//  BYPASS    1   1: a same-cycle write is forwarded to matching read ports
//  READ_REG  0   0: combinational reads; 1: read data registered, 1-cycle latency
//  ZERO_REG  1   1: R0 is hardwired to 0 (reads return 0, writes are dropped)
// PORTS
//  clock      in   1              rising-edge clock
//  reset_n    in   1              asynchronous, active-low reset
//  we         in   1              write enable
//  waddr      in   ADDR_W         write address
//  wdata      in   DATA_W         write data
//  raddr      in   NUM_RD*ADDR_W  read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rdata      out  NUM_RD*DATA_W  read data; port k = [k*DATA_W +: DATA_W]
//  clr_req    in   1              request a bulk clear; sampled only in IDLE
//  clr_busy   out  1              high while the sweep is in progress
//  clr_done   out  1              one-cycle pulse when the sweep completes
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): all registers = 0; FSM = IDLE; sweep counter = 0.
//    clr_busy = 0, clr_done = 0. In READ_REG=1 mode the rdata registers = 0.
//  - Write: at a rising edge with we=1, clr_busy=0 and a legal address, RF[waddr] <= wdata.
//    With ZERO_REG=1, waddr=0 is not a legal address and the write is dropped.
//  - Read, READ_REG=0: rdata[k] = RF[raddr[k]] combinationally.
//  - Read, READ_REG=1: rdata[k] is captured at the edge and holds the value from the
//    previous cycle's address. One cycle of latency.
//  - ZERO_REG=1: any read of address 0 returns 0, including when bypass would apply.
//  - BYPASS=1: a port whose raddr equals waddr, while an accepted write is pending
//    (we=1, clr_busy=0, legal address), returns wdata instead of the array value.
//    This gives write-then-read in the same cycle (combinational mode).
//    In READ_REG=1 mode, wdata is what gets captured.
//    BYPASS=0: the port returns the old array value (combinational mode).
//  - Clear FSM:
//    * IDLE -> SWEEP on an edge with clr_req=1. Counter <= 0; clr_busy = 1 from that edge.
//    * SWEEP: each edge sets RF[cnt] <= 0 and cnt <= cnt+1. On the edge with cnt=DEPTH-1,
//      the state goes to DONE. The sweep takes exactly DEPTH cycles.
//    * DONE: clr_busy = 0 and clr_done = 1 for one cycle. The next edge goes to IDLE
//      (clr_req is ignored in DONE).
//    * clr_req is ignored in SWEEP and DONE; there is no queuing.
//    * While clr_busy=1, writes are dropped and no bypass occurs. The upstream stage must stall.
//    * Reads during SWEEP return the current array contents: 0 for cnt'ed entries, old data above.
//    * clr_req and we in the same IDLE cycle: the write commits, then the sweep clears it.
//  - Counter width is ADDR_W; it does not wrap, because DONE is entered at DEPTH-1.
//  - reset_n asserted mid-sweep: immediate return to IDLE with all registers 0.
//    No clr_done pulse is produced.
//  - Multiple read ports may address the same register; all of them return identical data.
// TESTING
//  1. Reset, then read all 32 addresses -> every rdata = 0; clr_busy=0; clr_done=0.
//  2. Write R5=32'hDEADBEEF, then read R5 on both ports next cycle -> 32'hDEADBEEF on both.
//     Write R0=32'h1234 -> R0 reads 0.
//  3. BYPASS=1, READ_REG=0: we=1, waddr=7, wdata=32'hA5A5A5A5, raddr0=7 in the same cycle
//     -> rdata0=32'hA5A5A5A5 before the edge. BYPASS=0 -> old value 0.
//  4. Fill R1..R31 with their index, pulse clr_req
//     -> clr_busy high for exactly 32 cycles; clr_done pulses 1 cycle later.
//     All registers then read 0. A we=1 issued during busy is dropped.
//  5. Start a sweep, assert reset_n=0 at cnt=10 -> clr_busy=0 immediately; all reads 0;
//     no clr_done pulse.
//  6. READ_REG=1, NUM_RD=4: write R3=9; present raddr={3,3,0,3}
//     -> one cycle later rdata={9,9,0,9}.

Source files
------------

// File: rtl/dlx_rf_param.sv
`default_nettype none
// ============================================================================
// Module      : dlx_rf_param
// Description : Parametrised DLX register file with NUM_RD read ports and one
//               write port. It has optional write-to-read bypass, optional
//               registered reads, an optional hardwired R0, and a sequential
//               bulk-clear engine that zeroes one register per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_rf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     cnt;
  logic [DATA_W-1:0]     rf [DEPTH];

  logic                  wr_legal;
  logic                  wr_accept;

  // R0 is not writable when it is hardwired; writes are also frozen while sweeping.
  assign wr_legal  = (ZERO_REG == 0) || (waddr != '0);
  assign wr_accept = we && !clr_busy && wr_legal;

  // Clear engine: IDLE -> SWEEP (DEPTH cycles) -> DONE (one-cycle pulse) -> IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= S_SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        S_SWEEP: begin
          cnt <= cnt + ONE_IDX;
          if (cnt == LAST_IDX) begin
            state    <= S_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        S_DONE: begin
          clr_done <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: the sweep has priority; writes are only accepted when not busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (state == S_SWEEP) begin
      rf[cnt] <= '0;
    end else if (wr_accept) begin
      rf[waddr] <= wdata;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;

      assign ra = raddr[k*ADDR_W +: ADDR_W];

      // Port read value: array, overridden by bypass, overridden by hardwired R0.
      always_comb begin
        rd_val = rf[ra];
        if ((BYPASS != 0) && wr_accept && (ra == waddr)) begin
          rd_val = wdata;
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_val = '0;
        end
      end

      if (READ_REG != 0) begin : g_reg
        logic [DATA_W-1:0] rd_q;

        // Registered read: one cycle of latency, captures the bypassed value too.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            rd_q <= '0;
          end else begin
            rd_q <= rd_val;
          end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_q;
      end else begin : g_comb
        assign rdata[k*DATA_W +: DATA_W] = rd_val;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dlx_rf_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlx_rf_param
// Description : Directed self-checking bench for dlx_rf_param. Three instances
//               share the write/clear stimulus: default configuration, a
//               no-bypass variant and a registered-read 4-port variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlx_rf_param;

  logic          clock;
  logic          reset_n;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          clr_req;

  logic [9:0]    raddr;
  logic [63:0]   rdata_a;
  logic          busy_a, done_a;
  logic [63:0]   rdata_b;
  logic          busy_b, done_b;

  logic [19:0]   raddr_c;
  logic [127:0]  rdata_c;
  logic          busy_c, done_c;

  int            n_checks;
  int            n_errors;

  dlx_rf_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .READ_REG(0), .ZERO_REG(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  dlx_rf_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .READ_REG(0), .ZERO_REG(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  dlx_rf_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .READ_REG(1), .ZERO_REG(1)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_c), .rdata(rdata_c), .clr_req(clr_req), .clr_busy(busy_c), .clr_done(done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    clr_req  = 1'b0;
    raddr    = '0;
    raddr_c  = '0;

    // ---- 1: reset state ----
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    tick();
    check("rst_busy", {127'd0, busy_a}, 128'd0);
    check("rst_done", {127'd0, done_a}, 128'd0);
    check("rst_c_rdata", rdata_c, 128'd0);
    for (int i = 0; i < 32; i++) begin
      raddr = {i[4:0], i[4:0]};
      #1;
      check("rst_read", {64'd0, rdata_a}, 128'd0);
    end

    // ---- 2: basic write/read and R0 ----
    write_reg(5'd5, 32'hDEADBEEF);
    raddr = {5'd5, 5'd5};
    #1;
    check("r5_both", {64'd0, rdata_a}, {64'd0, 32'hDEADBEEF, 32'hDEADBEEF});
    write_reg(5'd0, 32'h1234);
    raddr = {5'd0, 5'd0};
    #1;
    check("r0_zero", {64'd0, rdata_a}, 128'd0);
    // Bypass must not leak a write to R0.
    we = 1'b1; waddr = 5'd0; wdata = 32'h5555; raddr = {5'd0, 5'd0};
    #1;
    check("r0_no_byp", {64'd0, rdata_a}, 128'd0);
    tick();
    we = 1'b0;

    // ---- 3: same-cycle bypass vs no bypass ----
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd5, 5'd7};
    #1;
    check("byp_a", {96'd0, rdata_a[31:0]}, {96'd0, 32'hA5A5A5A5});
    check("byp_a_p1", {96'd0, rdata_a[63:32]}, {96'd0, 32'hDEADBEEF});
    check("nobyp_b", {96'd0, rdata_b[31:0]}, 128'd0);
    tick();
    we = 1'b0;
    #1;
    check("after_wr_b", {96'd0, rdata_b[31:0]}, {96'd0, 32'hA5A5A5A5});

    // ---- 6: registered reads, 4 ports ----
    write_reg(5'd3, 32'd9);
    raddr_c = {5'd3, 5'd3, 5'd0, 5'd3};
    tick();
    check("rr_ports", rdata_c, {32'd9, 32'd9, 32'd0, 32'd9});
    raddr_c = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    check("rr_latency", rdata_c, {32'd9, 32'd9, 32'd0, 32'd9});
    tick();
    check("rr_next", rdata_c, {96'd0, 32'hDEADBEEF});
    we = 1'b1; waddr = 5'd4; wdata = 32'd77; raddr_c = {5'd0, 5'd0, 5'd0, 5'd4};
    tick();
    we = 1'b0;
    check("rr_bypass", rdata_c, {96'd0, 32'd77});

    // ---- 4: fill, sweep, drop writes during busy ----
    for (int i = 1; i < 32; i++) begin
      write_reg(i[4:0], i);
    end
    raddr = {5'd31, 5'd17};
    #1;
    check("fill", {64'd0, rdata_a}, {64'd0, 32'd31, 32'd17});
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    while (busy_a === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 11) begin
        // Sample after the 11th edge: cnt=10, entries 0..9 cleared.
        raddr = {5'd20, 5'd9};
        #1;
        check("mid_sweep", {64'd0, rdata_a}, {64'd0, 32'd20, 32'd0});
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
        raddr = {5'd20, 5'd20};
        #1;
        check("busy_no_byp", {96'd0, rdata_a[31:0]}, {96'd0, 32'd20});
      end
      tick();
    end
    we = 1'b0;
    check("busy_cycles", busy_cnt, 128'd32);
    check("done_pulse", {127'd0, done_a}, 128'd1);
    check("done_busy_lo", {127'd0, busy_a}, 128'd0);
    tick();
    check("done_cleared", {127'd0, done_a}, 128'd0);
    for (int i = 0; i < 32; i++) begin
      raddr = {i[4:0], i[4:0]};
      #1;
      check("post_clr", {64'd0, rdata_a}, 128'd0);
    end

    // ---- 5: reset during a sweep ----
    write_reg(5'd1, 32'd11);
    write_reg(5'd30, 32'd33);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy", {127'd0, busy_a}, 128'd1);
    raddr = {5'd30, 5'd30};
    #1;
    check("pre_rst_r30", {64'd0, rdata_a}, {64'd0, 32'd33, 32'd33});
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {127'd0, busy_a}, 128'd0);
    check("rst_mid_done", {127'd0, done_a}, 128'd0);
    for (int i = 0; i < 32; i++) begin
      raddr = {i[4:0], i[4:0]};
      #0.1;
      check("rst_mid_read", {64'd0, rdata_a}, 128'd0);
    end
    tick();
    #2;
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_a === 1'b1 || busy_a === 1'b1) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
